// File: rtl/mod_updown_counter.sv
// mod_updown_counter: synchronous modulo-MODULUS up/down counter.
//   - Parallel load takes priority over counting. An out-of-range load saturates
//     to MODULUS-1 and flags load_err for one cycle.
//   - tc is combinational and is high in the cycle whose edge produces a wrap.
//   - wrap is a registered one-cycle pulse that follows that edge.
// Optional feature: define MOD_COUNTER_STICKY_OVF_EN to add the ovf_clr and
// ovf_sticky ports and the sticky overflow flag behind them.
// Parameter legality: WIDTH >= 1, 2 <= MODULUS <= 2**WIDTH, RST_VAL < MODULUS.
module mod_updown_counter #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
`ifdef MOD_COUNTER_STICKY_OVF_EN
  ,
  input  logic             ovf_clr,
  output logic             ovf_sticky
`endif
);

  // Every compare and every next-state value is one bit wider than cnt. With
  // this width, MODULUS = 2**WIDTH stays representable and cannot overflow.
  localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   TOP_X = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0]   ONE_X = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);

  logic [WIDTH:0] cnt_x;
  logic [WIDTH:0] load_x;
  logic [WIDTH:0] nxt_x;
  logic           at_top;
  logic           at_bot;
  logic           load_ok;
  logic           wrap_nxt;
  logic           err_nxt;
  logic           unused_msb;

  assign cnt_x   = {1'b0, cnt};
  assign load_x  = {1'b0, load_val};
  assign at_top  = (cnt_x == TOP_X);
  assign at_bot  = (cnt_x == '0);
  assign load_ok = (load_x < MOD_X);

  // Terminal count: this cycle's edge will wrap if it counts.
  assign tc = en & ~load & (up ? at_top : at_bot);

  // Next-state selection: load beats count, and count beats hold.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    nxt_x    = cnt_x;
    wrap_nxt = 1'b0;
    err_nxt  = 1'b0;
    if (load) begin
      if (load_ok) begin
        nxt_x = load_x;
      end else begin
        nxt_x   = TOP_X;
        err_nxt = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        nxt_x    = at_top ? '0 : (cnt_x + ONE_X);
        wrap_nxt = at_top;
      end else begin
        nxt_x    = at_bot ? TOP_X : (cnt_x - ONE_X);
        wrap_nxt = at_bot;
      end
    end
  end

  // The top bit of nxt_x is always zero, because every selected value is < MODULUS.
  assign unused_msb = nxt_x[WIDTH];

  // Count register and one-cycle status pulses, with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments. All flops then update
    // together and do not depend on the order of the statements.
    if (rst) begin
      cnt      <= RST_V;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      cnt      <= nxt_x[WIDTH-1:0];
      wrap     <= wrap_nxt;
      load_err <= err_nxt;
    end
  end

`ifdef MOD_COUNTER_STICKY_OVF_EN
  // Sticky overflow flag: a wrap sets it and ovf_clr clears it. When both
  // occur on the same edge, the set wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else if (wrap_nxt) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end
`endif

endmodule
